// File: rtl/renode_apb3_requester_if.sv
// rtl/renode_apb3_requester_if.sv - request/response and APB3 signal bundle for renode_apb3_requester
interface renode_apb3_requester_if #(
    parameter int AddressWidth = 20,
    parameter int DataWidth    = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic [AddressWidth-1:0] req_addr;
    logic                    req_write;
    logic [DataWidth-1:0]    req_wdata;
    logic                    rsp_valid;
    logic [DataWidth-1:0]    rsp_rdata;
    logic                    rsp_error;
    logic [AddressWidth-1:0] paddr;
    logic                    pselx;
    logic                    penable;
    logic                    pwrite;
    logic [DataWidth-1:0]    pwdata;
    logic                    pready;
    logic [DataWidth-1:0]    prdata;
    logic                    pslverr;

    // master: the requester itself; slave: whoever drives requests and plays the completer
    modport master (
        input  req_valid, req_addr, req_write, req_wdata, pready, prdata, pslverr,
        output req_ready, rsp_valid, rsp_rdata, rsp_error, paddr, pselx, penable, pwrite, pwdata
    );
    modport slave (
        output req_valid, req_addr, req_write, req_wdata, pready, prdata, pslverr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error, paddr, pselx, penable, pwrite, pwdata
    );
endinterface

// File: rtl/renode_apb3_requester.sv
// rtl/renode_apb3_requester.sv - APB3 requester turning single-word requests into APB3 transfers
// Optional ACCESS-phase watchdog: define RENODE_APB3_REQUESTER_TIMEOUT_EN.
module renode_apb3_requester #(
    parameter int AddressWidth  = 20,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 256
) (
    input  logic                     pclk,
    input  logic                     presetn,
    renode_apb3_requester_if.master  bus
);
    if ((DataWidth != 8 && DataWidth != 16 && DataWidth != 32) ||
        TimeoutCycles < 1 || TimeoutCycles > 65535 || AddressWidth < 1) begin : g_param_check
        $error("renode_apb3_requester: illegal parameter value");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [AddressWidth-1:0] paddr_q, paddr_d;
    logic                    pwrite_q, pwrite_d;
    logic [DataWidth-1:0]    pwdata_q, pwdata_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DataWidth-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_error_q, rsp_error_d;

`ifdef RENODE_APB3_REQUESTER_TIMEOUT_EN
    localparam logic [15:0] TimeoutLimit = 16'(TimeoutCycles);
    logic [15:0] wait_cnt_q, wait_cnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
`ifdef RENODE_APB3_REQUESTER_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    paddr_d  = bus.req_addr;
                    pwrite_d = bus.req_write;
                    pwdata_d = bus.req_wdata;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
`ifdef RENODE_APB3_REQUESTER_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            ACCESS: begin
                if (bus.pready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = bus.pslverr;
                    rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
                end
`ifdef RENODE_APB3_REQUESTER_TIMEOUT_EN
                else begin
                    // The wait cycle that brings the count to the limit is the last one tolerated
                    wait_cnt_d = wait_cnt_q + 16'd1;
                    if (wait_cnt_d == TimeoutLimit) begin
                        state_d     = IDLE;
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                        rsp_rdata_d = '0;
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_q     <= IDLE;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
`ifdef RENODE_APB3_REQUESTER_TIMEOUT_EN
            wait_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
`ifdef RENODE_APB3_REQUESTER_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
`endif
        end
    end

    assign bus.req_ready = presetn && (state_q == IDLE);
    assign bus.pselx     = (state_q != IDLE);
    assign bus.penable   = (state_q == ACCESS);
    assign bus.paddr     = paddr_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_error = rsp_error_q;
endmodule

// File: tb/tb_renode_apb3_requester.sv
// tb/tb_renode_apb3_requester.sv - self-checking bench for renode_apb3_requester
module tb_renode_apb3_requester;
    localparam int AW = 20;
    localparam int DW = 32;
    localparam int TO = 8;

    logic pclk = 1'b0;
    logic presetn = 1'b0;
    always #5 pclk = ~pclk;

    renode_apb3_requester_if #(.AddressWidth(AW), .DataWidth(DW)) bus ();

    renode_apb3_requester #(
        .AddressWidth(AW),
        .DataWidth(DW),
        .TimeoutCycles(TO)
    ) dut (
        .pclk(pclk),
        .presetn(presetn),
        .bus(bus)
    );

    int checks = 0;
    int fails  = 0;
    logic [DW-1:0] last_rdata = '0;
    logic          last_err   = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge pclk);
        @(negedge pclk);
    endtask

    task automatic scramble_completer();
        bus.pready  = 1'($urandom);
        bus.prdata  = $urandom;
        bus.pslverr = 1'($urandom);
    endtask

    // One transfer from the idle negedge to the response negedge. Expected timing:
    // SETUP one cycle, ACCESS waits+1 cycles, then a one-cycle response.
    task automatic xfer(input string nm, input logic [AW-1:0] addr, input logic wr,
                        input logic [DW-1:0] wdata, input int waits,
                        input logic [DW-1:0] rdata, input logic err, input logic hold);
        logic [DW-1:0] exp_rdata;
        check({nm, ".req_ready"}, bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_write = wr;
        bus.req_wdata = wdata;
        cyc();
        bus.req_valid = hold;
        bus.req_addr  = AW'($urandom);
        bus.req_write = 1'($urandom);
        bus.req_wdata = $urandom;
        check({nm, ".setup_psel"}, {bus.pselx, bus.penable}, 2'b10);
        check({nm, ".setup_paddr"}, bus.paddr, addr);
        check({nm, ".setup_pwrite"}, bus.pwrite, wr);
        check({nm, ".setup_pwdata"}, bus.pwdata, wdata);
        check({nm, ".setup_busy"}, {bus.req_ready, bus.rsp_valid}, 2'b00);
        check({nm, ".rsp_hold"}, {bus.rsp_error, bus.rsp_rdata}, {last_err, last_rdata});
        scramble_completer();
        for (int i = 0; i <= waits; i++) begin
            cyc();
            check($sformatf("%s.access%0d_psel", nm, i), {bus.pselx, bus.penable}, 2'b11);
            check($sformatf("%s.access%0d_stable", nm, i),
                  {bus.paddr, bus.pwrite, bus.pwdata}, {addr, wr, wdata});
            check($sformatf("%s.access%0d_norsp", nm, i), bus.rsp_valid, 0);
            bus.pready  = (i == waits);
            bus.prdata  = (i == waits) ? rdata : $urandom;
            bus.pslverr = (i == waits) ? err : 1'($urandom);
        end
        cyc();
        exp_rdata = wr ? '0 : rdata;
        check({nm, ".rsp_valid"}, bus.rsp_valid, 1);
        check({nm, ".rsp_rdata"}, bus.rsp_rdata, exp_rdata);
        check({nm, ".rsp_error"}, bus.rsp_error, err);
        check({nm, ".idle_psel"}, {bus.pselx, bus.penable, bus.req_ready}, 3'b001);
        check({nm, ".addr_hold"}, {bus.paddr, bus.pwrite, bus.pwdata}, {addr, wr, wdata});
        last_rdata = exp_rdata;
        last_err   = err;
        scramble_completer();
        bus.req_valid = 1'b0;
    endtask

    initial begin
        int bad;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_write = 1'b0;
        bus.req_wdata = '0;
        bus.pready    = 1'b1;
        bus.prdata    = '0;
        bus.pslverr   = 1'b0;

        presetn = 1'b0;
        bus.req_valid = 1'b1;
        @(negedge pclk);
        cyc();
        check("reset.req_ready", bus.req_ready, 0);
        check("reset.apb", {bus.pselx, bus.penable, bus.pwrite}, 3'b000);
        check("reset.regs", {bus.paddr, bus.pwdata}, '0);
        check("reset.rsp", {bus.rsp_valid, bus.rsp_error, bus.rsp_rdata}, '0);
        bus.req_valid = 1'b0;
        presetn = 1'b1;
        cyc();
        check("idle.after_reset", {bus.pselx, bus.req_ready}, 2'b01);

        xfer("wr0", 20'h00010, 1'b1, 32'hDEADBEEF, 0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        xfer("rd4", 20'h00100, 1'b0, 32'h0, 4, 32'h12345678, 1'b0, 1'b0);
        xfer("slverr", 20'h00200, 1'b0, 32'h0, 1, 32'hCAFE0001, 1'b1, 1'b0);
        xfer("after_err", 20'h00204, 1'b1, 32'h0BAD_F00D, 0, 32'h5, 1'b0, 1'b0);

        for (int k = 0; k < 3; k++)
            xfer($sformatf("b2b%0d", k), AW'($urandom), 1'(k == 1), $urandom, 0,
                 $urandom, 1'($urandom), 1'(k < 2));

        for (int k = 0; k < 20; k++)
            xfer($sformatf("rnd%0d", k), AW'($urandom), 1'($urandom), $urandom,
                 (k == 0) ? TO - 1 : int'($urandom_range(0, TO - 1)),
                 $urandom, 1'($urandom), 1'($urandom));
        cyc();
        check("idle.rsp_drop", {bus.rsp_valid, bus.pselx}, 2'b00);

        bus.req_valid = 1'b1;
        bus.req_addr  = 20'h00300;
        bus.req_write = 1'b0;
        cyc();
        bus.req_valid = 1'b0;
        bus.pready    = 1'b0;
`ifdef RENODE_APB3_REQUESTER_TIMEOUT_EN
        for (int i = 0; i < TO; i++) begin
            cyc();
            check($sformatf("to.wait%0d", i), {bus.pselx, bus.penable, bus.rsp_valid}, 3'b110);
        end
        cyc();
        check("to.abort_psel", {bus.pselx, bus.penable}, 2'b00);
        check("to.rsp", {bus.rsp_valid, bus.rsp_error, bus.rsp_rdata}, {2'b11, 32'h0});
        cyc();
        check("to.rsp_drop", bus.rsp_valid, 0);
`else
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            cyc();
            if ({bus.pselx, bus.penable, bus.rsp_valid} !== 3'b110) bad++;
        end
        check("noto.stuck_cycles_bad", bad, 0);
`endif

        if (bus.req_ready) begin
            bus.req_valid = 1'b1;
            bus.req_addr  = 20'h00400;
            bus.req_write = 1'b1;
            bus.req_wdata = 32'h1111_2222;
            cyc();
            bus.req_valid = 1'b0;
            cyc();
            cyc();
        end
        check("rst.in_wait", {bus.pselx, bus.penable}, 2'b11);
        presetn = 1'b0;
        #1;
        check("rst.req_ready_forced", bus.req_ready, 0);
        @(negedge pclk);
        check("rst.apb_drop", {bus.pselx, bus.penable, bus.rsp_valid}, 3'b000);
        check("rst.regs", {bus.paddr, bus.pwrite, bus.pwdata, bus.rsp_error, bus.rsp_rdata}, '0);
        presetn = 1'b1;
        bus.pready = 1'b1;
        cyc();
        check("rst.no_rsp", {bus.rsp_valid, bus.pselx}, 2'b00);
        last_rdata = '0;
        last_err   = 1'b0;
        xfer("post_rst", 20'h00500, 1'b0, 32'h0, 2, 32'hA5A5_5A5A, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule
